// File: rtl/register_bank_8_pkg.sv
// Shared register-file constants, reused by the decoder and operand mux.
package register_bank_8_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int DATA_W_DEF = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One-hot decode of a register address, gated by a strobe.
  function automatic logic [NUM_REGS-1:0] addr_mask(input logic en, input reg_addr_t addr);
    addr_mask = en ? (NUM_REGS'(1) << addr) : '0;
  endfunction
endpackage

// File: rtl/register_bank_8_if.sv
// Writeback/reservation/read bus of the register bank.
interface register_bank_8_if #(parameter int WIDTH = 16);
  import register_bank_8_pkg::*;

  logic                               wr_en;
  reg_addr_t                          wr_addr;
  logic [WIDTH-1:0]                   wr_data;
  logic                               rsv_en;
  reg_addr_t                          rsv_addr;
  reg_addr_t                          rd_sel;
  logic [NUM_REGS-1:0][WIDTH-1:0]     r;
  logic [NUM_REGS-1:0]                busy;
  logic                               stall;
  logic                               rsv_err;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_sel,
    input  r, busy, stall, rsv_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_sel,
    output r, busy, stall, rsv_err
  );
endinterface

// File: rtl/register_bank_8_reg_cell.sv
// Single WIDTH-bit data register with load enable and async active-high reset.
module reg_cell #(parameter int WIDTH = 16) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

// File: rtl/register_bank_8.sv
// Eight-entry register bank with per-register busy scoreboard and reservation error pulse.
// Optional REG_BANK_BYPASS_EN: forwards the writeback onto R/BUSY in the write cycle.
module register_bank_8
  import register_bank_8_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  register_bank_8_if.slave bus
);
  logic [NUM_REGS-1:0][WIDTH-1:0] cell_q;
  logic [NUM_REGS-1:0]            wr_mask, rsv_mask;
  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic                           rsv_err_q, rsv_err_d;

  assign wr_mask  = addr_mask(bus.wr_en,  bus.wr_addr);
  assign rsv_mask = addr_mask(bus.rsv_en, bus.rsv_addr);

  // Reservation wins over a same-edge writeback: it belongs to the newer producer.
  assign busy_d    = (busy_q & ~wr_mask) | rsv_mask;
  assign rsv_err_d = |(rsv_mask & busy_q & ~wr_mask);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (wr_mask[i]),
      .d_i   (bus.wr_data),
      .q_o   (cell_q[i])
    );
`ifdef REG_BANK_BYPASS_EN
    assign bus.r[i] = wr_mask[i] ? bus.wr_data : cell_q[i];
`else
    assign bus.r[i] = cell_q[i];
`endif
  end

`ifdef REG_BANK_BYPASS_EN
  assign bus.busy = busy_q & ~(wr_mask & ~rsv_mask);
`else
  assign bus.busy = busy_q;
`endif

  assign bus.stall   = bus.busy[bus.rd_sel];
  assign bus.rsv_err = rsv_err_q;
endmodule

// File: tb/tb_register_bank_8.sv
// Directed self-checking bench for register_bank_8 (checks follow REG_BANK_BYPASS_EN).
module tb_register_bank_8;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  register_bank_8_if #(.WIDTH(W)) bus ();

  register_bank_8 #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.rsv_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_sel = '0;

    // Reset state
    #12;
    chk("rst_r0",     32'(bus.r[0]), 32'h0);
    chk("rst_r7",     32'(bus.r[7]), 32'h0);
    chk("rst_busy",   32'(bus.busy), 32'h00);
    chk("rst_stall",  32'(bus.stall), 32'h0);
    chk("rst_rsverr", 32'(bus.rsv_err), 32'h0);
    rst = 1'b0;
    tick();

    // 1: load R3 and reserve it, then async reset mid-cycle
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'h1234;
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd3; bus.rd_sel = 3'd3;
    tick(); idle();
    chk("t1_r3_pre",   32'(bus.r[3]), 32'h1234);
    chk("t1_busy_pre", 32'(bus.busy), 32'h08);
    chk("t1_stall_pre",32'(bus.stall), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t1_r3_rst",    32'(bus.r[3]), 32'h0);
    chk("t1_busy_rst",  32'(bus.busy), 32'h00);
    chk("t1_stall_rst", 32'(bus.stall), 32'h0);
    chk("t1_err_rst",   32'(bus.rsv_err), 32'h0);
    #1 rst = 1'b0;
    tick();

    // 2: reserve R5, stall on it, then write back
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd5;
    tick(); idle();
    bus.rd_sel = 3'd5;
    #1;
    chk("t2_busy",  32'(bus.busy), 32'h20);
    chk("t2_stall", 32'(bus.stall), 32'h1);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'hBEEF;
    tick(); idle();
    chk("t2_r5",      32'(bus.r[5]), 32'hBEEF);
    chk("t2_busy_wb", 32'(bus.busy), 32'h00);
    chk("t2_stall_wb",32'(bus.stall), 32'h0);

    // 3: same-edge write and reserve of R2
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h00AA;
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd2;
    tick(); idle();
    chk("t3_r2",   32'(bus.r[2]), 32'h00AA);
    chk("t3_busy", 32'(bus.busy), 32'h04);
    chk("t3_err",  32'(bus.rsv_err), 32'h0);

    // 4: double reservation of R6 pulses RSV_ERR for one cycle
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd6;
    tick();
    chk("t4_err_first", 32'(bus.rsv_err), 32'h0);
    tick(); idle();
    chk("t4_err_pulse", 32'(bus.rsv_err), 32'h1);
    chk("t4_busy",      32'(bus.busy), 32'h44);
    tick();
    chk("t4_err_clear", 32'(bus.rsv_err), 32'h0);
    chk("t4_busy_hold", 32'(bus.busy), 32'h44);

    // 5: write to idle R0
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'hFFFF;
    tick(); idle();
    chk("t5_r0",   32'(bus.r[0]), 32'hFFFF);
    chk("t5_busy", 32'(bus.busy), 32'h44);
    chk("t5_err",  32'(bus.rsv_err), 32'h0);

    // Same edge, different addresses: write R2 (clears), reserve R1
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h1111;
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd1;
    tick(); idle();
    chk("tx_r2",   32'(bus.r[2]), 32'h1111);
    chk("tx_busy", 32'(bus.busy), 32'h42);
    chk("tx_err",  32'(bus.rsv_err), 32'h0);

    // 6: reserve R7, then write it and look within the write cycle
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd7;
    tick(); idle();
    chk("t6_busy_rsv", 32'(bus.busy), 32'hC2);
    bus.rd_sel = 3'd7;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 16'h5A5A;
    #1;
`ifdef REG_BANK_BYPASS_EN
    chk("t6_r7_same",    32'(bus.r[7]), 32'h5A5A);
    chk("t6_busy_same",  32'(bus.busy), 32'h42);
    chk("t6_stall_same", 32'(bus.stall), 32'h0);
`else
    chk("t6_r7_same",    32'(bus.r[7]), 32'h0);
    chk("t6_busy_same",  32'(bus.busy), 32'hC2);
    chk("t6_stall_same", 32'(bus.stall), 32'h1);
`endif
    tick(); idle();
    chk("t6_r7_next",    32'(bus.r[7]), 32'h5A5A);
    chk("t6_busy_next",  32'(bus.busy), 32'h42);
    chk("t6_stall_next", 32'(bus.stall), 32'h0);
    chk("t6_r5_keep",    32'(bus.r[5]), 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
